// File: rtl/decode_pkg.sv
// Shared decode types: ALU/branch/shift selectors, immediate formats,
// RV32I/RV64I opcodes and the control bundle handed from decode to execute.
package decode_pkg;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_XOR    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_AND    = 4'd4,
      ALU_PASSB  = 4'd5,
      ALU_MUL    = 4'd6,
      ALU_MULH   = 4'd7,
      ALU_MULHSU = 4'd8,
      ALU_MULHU  = 4'd9,
      ALU_DIV    = 4'd10,
      ALU_DIVU   = 4'd11,
      ALU_REM    = 4'd12,
      ALU_REMU   = 4'd13
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
   } branch_e;

   typedef enum logic [1:0] {
      SH_SLL, SH_SRL, SH_SRA
   } shift_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
   } imm_fmt_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      alu_op_e    alu_op;
      branch_e    branch_type;
      shift_e     shift_type;
      logic [3:0] xfer_size;
      logic       reg_write;
      logic       alu_src;
      logic       auipc;
      logic       shift;
      logic       slt;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       jump;
      logic       jalr;
      logic       is_unsigned;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side valid/ready channels of the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's.
interface decode_stage_if
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   ctrl_t           out_ctrl;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_imm,
      output out_rs1, out_rs2, out_rd, out_ctrl
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_imm,
      input  out_rs1, out_rs2, out_rd, out_ctrl
   );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I(+M) instruction decoder:
// control bundle, sign-extended immediate and register indices.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]     instr,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            uses_rs1,
   output logic            uses_rs2
);
   localparam bit RV64 = (XLEN == 64);

   logic [6:0]         opc;
   logic [6:0]         f7;
   logic [2:0]         f3;
   imm_fmt_e           fmt;
   logic               bad;
   logic               u1;
   logic               u2;
   ctrl_t              c;
   logic signed [31:0] imm32;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];

   always_comb begin
      c   = '0;
      fmt = IMM_NONE;
      bad = 1'b0;
      u1  = 1'b0;
      u2  = 1'b0;
      unique case (1'b1)
         opc == OPC_LUI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = ALU_PASSB;
            fmt         = IMM_U;
         end
         opc == OPC_AUIPC: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.auipc     = 1'b1;
            fmt         = IMM_U;
         end
         opc == OPC_JAL: begin
            c.reg_write = 1'b1;
            c.jump      = 1'b1;
            fmt         = IMM_J;
         end
         opc == OPC_JALR: begin
            u1          = 1'b1;
            bad         = (f3 != 3'b000);
            c.reg_write = 1'b1;
            c.jump      = 1'b1;
            c.jalr      = 1'b1;
            c.alu_src   = 1'b1;
            fmt         = IMM_I;
         end
         opc == OPC_BRANCH: begin
            u1            = 1'b1;
            u2            = 1'b1;
            c.alu_op      = ALU_SUB;
            c.is_unsigned = (f3[2:1] == 2'b11);
            fmt           = IMM_B;
            case (f3)
               3'b000:  c.branch_type = BR_EQ;
               3'b001:  c.branch_type = BR_NE;
               3'b100:  c.branch_type = BR_LT;
               3'b101:  c.branch_type = BR_GE;
               3'b110:  c.branch_type = BR_LTU;
               3'b111:  c.branch_type = BR_GEU;
               default: bad = 1'b1;
            endcase
         end
         opc == OPC_LOAD: begin
            u1           = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_src    = 1'b1;
            fmt          = IMM_I;
            c.is_unsigned = f3[2];
            case (f3)
               3'b000, 3'b100: c.xfer_size = 4'd1;
               3'b001, 3'b101: c.xfer_size = 4'd2;
               3'b010:  c.xfer_size = 4'd4;
               3'b011: begin
                  c.xfer_size = 4'd8;
                  bad         = !RV64;
               end
               3'b110: begin
                  c.xfer_size = 4'd4;
                  bad         = !RV64;
               end
               default: bad = 1'b1;
            endcase
         end
         opc == OPC_STORE: begin
            u1          = 1'b1;
            u2          = 1'b1;
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
            fmt         = IMM_S;
            case (f3)
               3'b000:  c.xfer_size = 4'd1;
               3'b001:  c.xfer_size = 4'd2;
               3'b010:  c.xfer_size = 4'd4;
               3'b011: begin
                  c.xfer_size = 4'd8;
                  bad         = !RV64;
               end
               default: bad = 1'b1;
            endcase
         end
         opc == OPC_OPIMM: begin
            u1          = 1'b1;
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            fmt         = IMM_I;
            case (f3)
               3'b000: c.alu_op = ALU_ADD;
               3'b010: begin
                  c.alu_op = ALU_SUB;
                  c.slt    = 1'b1;
               end
               3'b011: begin
                  c.alu_op      = ALU_SUB;
                  c.slt         = 1'b1;
                  c.is_unsigned = 1'b1;
               end
               3'b100: c.alu_op = ALU_XOR;
               3'b110: c.alu_op = ALU_OR;
               3'b111: c.alu_op = ALU_AND;
               3'b001: begin
                  c.shift = 1'b1;
                  fmt     = IMM_SH;
                  bad     = RV64 ? (instr[31:26] != 6'd0)
                                 : (f7 != 7'd0);
               end
               default: begin
                  c.shift      = 1'b1;
                  c.shift_type = instr[30] ? SH_SRA : SH_SRL;
                  fmt          = IMM_SH;
                  // bit 30 picks arithmetic; bit 25 is shamt[5] on RV64 only
                  bad = RV64 ? ({instr[31], instr[29:26]} != 5'd0)
                             : ({instr[31], instr[29:25]} != 6'd0);
               end
            endcase
         end
         opc == OPC_OP: begin
            u1          = 1'b1;
            u2          = 1'b1;
            c.reg_write = 1'b1;
            if (f7 == 7'b0000001) begin
               bad      = !ENABLE_M;
               c.alu_op = alu_op_e'(4'(ALU_MUL) + {1'b0, f3});
               c.is_unsigned = (f3 == 3'b011) || (f3 == 3'b101)
                             || (f3 == 3'b111);
            end else if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
               bad = f7[5] && (f3 != 3'b000) && (f3 != 3'b101);
               case (f3)
                  3'b000: c.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                  3'b001: c.shift = 1'b1;
                  3'b010: begin
                     c.alu_op = ALU_SUB;
                     c.slt    = 1'b1;
                  end
                  3'b011: begin
                     c.alu_op      = ALU_SUB;
                     c.slt         = 1'b1;
                     c.is_unsigned = 1'b1;
                  end
                  3'b100: c.alu_op = ALU_XOR;
                  3'b101: begin
                     c.shift      = 1'b1;
                     c.shift_type = f7[5] ? SH_SRA : SH_SRL;
                  end
                  3'b110:  c.alu_op = ALU_OR;
                  default: c.alu_op = ALU_AND;
               endcase
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase

      if (bad) begin
         c         = '0;
         c.illegal = 1'b1;
         u1        = 1'b0;
         u2        = 1'b0;
         fmt       = IMM_NONE;
      end
   end

   always_comb begin
      imm32 = '0;
      case (fmt)
         IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
         IMM_U:  imm32 = {instr[31:12], 12'd0};
         IMM_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
         IMM_SH: imm32 = RV64 ? {26'd0, instr[25:20]}
                              : {27'd0, instr[24:20]};
         default: imm32 = '0;
      endcase
   end

   assign ctrl     = c;
   assign imm      = XLEN'(imm32);
   assign uses_rs1 = u1;
   assign uses_rs2 = u2;
   assign rs1      = u1 ? instr[19:15] : 5'd0;
   assign rs2      = u2 ? instr[24:20] : 5'd0;
   assign rd       = c.reg_write ? instr[11:7] : 5'd0;
endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use bubble
// insertion against EX, flush, and a load-use stall cycle counter.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   decode_stage_if.slave bus,
   input  logic          flush,
   input  logic          ex_mem_read,
   input  logic [4:0]    ex_rd,
   output logic [31:0]   stall_count
);
   if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
      $error("decode_stage: XLEN must be 32 or 64");
   end

   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [4:0]      dec_rd;
   logic            dec_u1;
   logic            dec_u2;

   decode_comb #(
      .XLEN     (XLEN),
      .ENABLE_M (ENABLE_M)
   ) u_comb (
      .instr    (bus.in_instr),
      .ctrl     (dec_ctrl),
      .imm      (dec_imm),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd),
      .uses_rs1 (dec_u1),
      .uses_rs2 (dec_u2)
   );

   logic            hazard;
   logic            in_ready;
   logic            xfer_in;
   logic            xfer_out;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [4:0]      rd_q, rd_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [31:0]     stall_q, stall_d;

   always_comb begin
      hazard = bus.in_valid && ex_mem_read && (ex_rd != 5'd0)
             && ((dec_u1 && dec_rs1 == ex_rd)
              || (dec_u2 && dec_rs2 == ex_rd));
      in_ready = (!valid_q || bus.out_ready) && !hazard && !flush;
      xfer_in  = bus.in_valid && in_ready;
      xfer_out = valid_q && bus.out_ready;

      valid_d = valid_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (xfer_in) begin
         valid_d = 1'b1;
         pc_d    = bus.in_pc;
         imm_d   = dec_imm;
         rs1_d   = dec_rs1;
         rs2_d   = dec_rs2;
         rd_d    = dec_rd;
         ctrl_d  = dec_ctrl;
      end else if (xfer_out) begin
         valid_d = 1'b0;
      end
      stall_d = stall_q + {31'd0, hazard && !flush};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
         stall_q <= stall_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_pc    = pc_q;
   assign bus.out_imm   = imm_q;
   assign bus.out_rs1   = rs1_q;
   assign bus.out_rs2   = rs2_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_ctrl  = ctrl_q;
   assign stall_count   = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32+M instance and an RV64
// instance without M share control inputs and instruction stimulus.
module tb_decode_stage;
   import decode_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic [31:0] stall32;
   logic [31:0] stall64;
   int          checks;
   int          passed;
   ctrl_t       ill;

   decode_stage_if #(.XLEN(32)) b32 ();
   decode_stage_if #(.XLEN(64)) b64 ();

   decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u_dut32 (
      .clk         (clk),
      .reset       (reset),
      .bus         (b32.slave),
      .flush       (flush),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .stall_count (stall32)
   );

   decode_stage #(.XLEN(64), .ENABLE_M(1'b0)) u_dut64 (
      .clk         (clk),
      .reset       (reset),
      .bus         (b64.slave),
      .flush       (flush),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .stall_count (stall64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] ins,
                         input logic [63:0] pc);
      b32.in_valid = v;
      b32.in_instr = ins;
      b32.in_pc    = pc[31:0];
      b64.in_valid = v;
      b64.in_instr = ins;
      b64.in_pc    = pc;
   endtask

   task automatic set_ready(input logic r);
      b32.out_ready = r;
      b64.out_ready = r;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
      set_in(1'b1, ins, pc);
      step();
      set_in(1'b0, 32'h0, 64'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      ex_mem_read = 1'b0;
      ex_rd = 5'd0;
      set_in(1'b0, 32'h0, 64'h0);
      set_ready(1'b1);
      repeat (2) step();
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL rst_valid32 got %0b exp 0", b32.out_valid); else passed++;
      checks++; if (b64.out_valid !== 1'b0) $display("FAIL rst_valid64 got %0b exp 0", b64.out_valid); else passed++;
      checks++; if (b32.out_ctrl !== ctrl_t'('0)) $display("FAIL rst_ctrl got %h exp 0", b32.out_ctrl); else passed++;
      checks++; if (stall32 !== 32'd0) $display("FAIL rst_stall got %0d exp 0", stall32); else passed++;
      checks++; if (b32.out_pc !== 32'd0) $display("FAIL rst_pc got %h exp 0", b32.out_pc); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_addi();
      set_in(1'b1, 32'h00500093, 64'h100);
      #1;
      checks++; if (b32.in_ready !== 1'b1) $display("FAIL addi_in_ready got %0b exp 1", b32.in_ready); else passed++;
      step();
      set_in(1'b0, 32'h0, 64'h0);
      checks++; if (b32.out_valid !== 1'b1) $display("FAIL addi_valid got %0b exp 1", b32.out_valid); else passed++;
      checks++; if (b32.out_pc !== 32'h100) $display("FAIL addi_pc got %h exp 100", b32.out_pc); else passed++;
      checks++; if (b32.out_imm !== 32'd5) $display("FAIL addi_imm got %h exp 5", b32.out_imm); else passed++;
      checks++; if (b32.out_rd !== 5'd1) $display("FAIL addi_rd got %0d exp 1", b32.out_rd); else passed++;
      checks++; if (b32.out_ctrl.alu_op !== ALU_ADD) $display("FAIL addi_aluop got %0d exp 0", b32.out_ctrl.alu_op); else passed++;
      checks++; if (b32.out_ctrl.alu_src !== 1'b1) $display("FAIL addi_alusrc got %0b exp 1", b32.out_ctrl.alu_src); else passed++;
      checks++; if (b32.out_ctrl.reg_write !== 1'b1) $display("FAIL addi_regwr got %0b exp 1", b32.out_ctrl.reg_write); else passed++;
      checks++; if (b64.out_imm !== 64'd5) $display("FAIL addi_imm64 got %h exp 5", b64.out_imm); else passed++;
      step();
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL addi_drain got %0b exp 0", b32.out_valid); else passed++;
   endtask

   task automatic test_load_use();
      ex_mem_read = 1'b1;
      ex_rd = 5'd1;
      set_in(1'b1, 32'h00108133, 64'h104);
      #1;
      checks++; if (b32.in_ready !== 1'b0) $display("FAIL lu_ready_c0 got %0b exp 0", b32.in_ready); else passed++;
      step();
      checks++; if (b32.in_ready !== 1'b0) $display("FAIL lu_ready_c1 got %0b exp 0", b32.in_ready); else passed++;
      step();
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL lu_bubble got %0b exp 0", b32.out_valid); else passed++;
      checks++; if (stall32 !== 32'd2) $display("FAIL lu_stall32 got %0d exp 2", stall32); else passed++;
      checks++; if (stall64 !== 32'd2) $display("FAIL lu_stall64 got %0d exp 2", stall64); else passed++;
      ex_mem_read = 1'b0;
      #1;
      checks++; if (b32.in_ready !== 1'b1) $display("FAIL lu_release got %0b exp 1", b32.in_ready); else passed++;
      step();
      set_in(1'b0, 32'h0, 64'h0);
      checks++; if (b32.out_valid !== 1'b1) $display("FAIL lu_accept got %0b exp 1", b32.out_valid); else passed++;
      checks++; if (b32.out_pc !== 32'h104) $display("FAIL lu_pc got %h exp 104", b32.out_pc); else passed++;
      checks++; if ({b32.out_rs1, b32.out_rs2, b32.out_rd} !== {5'd1, 5'd1, 5'd2}) $display("FAIL lu_regs got %h exp %h", {b32.out_rs1, b32.out_rs2, b32.out_rd}, {5'd1, 5'd1, 5'd2}); else passed++;
      checks++; if (stall32 !== 32'd2) $display("FAIL lu_stall_hold got %0d exp 2", stall32); else passed++;
      step();
   endtask

   task automatic test_mul();
      issue(32'h022081B3, 64'h108);
      checks++; if (b32.out_ctrl.alu_op !== ALU_MUL) $display("FAIL mul_aluop got %0d exp 6", b32.out_ctrl.alu_op); else passed++;
      checks++; if (b32.out_ctrl.reg_write !== 1'b1) $display("FAIL mul_regwr got %0b exp 1", b32.out_ctrl.reg_write); else passed++;
      checks++; if (b32.out_rd !== 5'd3) $display("FAIL mul_rd got %0d exp 3", b32.out_rd); else passed++;
      checks++; if (b64.out_ctrl !== ill) $display("FAIL mul_nom_ctrl got %h exp %h", b64.out_ctrl, ill); else passed++;
      checks++; if (b64.out_rd !== 5'd0) $display("FAIL mul_nom_rd got %0d exp 0", b64.out_rd); else passed++;
      checks++; if (b64.out_valid !== 1'b1) $display("FAIL mul_nom_valid got %0b exp 1", b64.out_valid); else passed++;
      step();
   endtask

   task automatic test_back_pressure();
      issue(32'h00500093, 64'h10C);
      set_ready(1'b0);
      set_in(1'b1, 32'hFFF00293, 64'h110);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (b32.in_ready !== 1'b0) $display("FAIL bp_ready%0d got %0b exp 0", i, b32.in_ready); else passed++;
         step();
         checks++; if ({b32.out_valid, b32.out_pc, b32.out_imm} !== {1'b1, 32'h10C, 32'd5}) $display("FAIL bp_hold%0d got %h exp %h", i, {b32.out_valid, b32.out_pc, b32.out_imm}, {1'b1, 32'h10C, 32'd5}); else passed++;
      end
      set_ready(1'b1);
      #1;
      checks++; if (b32.in_ready !== 1'b1) $display("FAIL bp_release got %0b exp 1", b32.in_ready); else passed++;
      step();
      checks++; if (b32.out_valid !== 1'b1) $display("FAIL bp_nobubble got %0b exp 1", b32.out_valid); else passed++;
      checks++; if (b32.out_pc !== 32'h110) $display("FAIL bp_pc got %h exp 110", b32.out_pc); else passed++;
      checks++; if (b32.out_imm !== 32'hFFFFFFFF) $display("FAIL bp_imm32 got %h exp ffffffff", b32.out_imm); else passed++;
      checks++; if (b64.out_imm !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL bp_imm64 got %h exp all ones", b64.out_imm); else passed++;
      checks++; if (b32.out_rd !== 5'd5) $display("FAIL bp_rd got %0d exp 5", b32.out_rd); else passed++;
   endtask

   task automatic test_flush();
      ex_mem_read = 1'b1;
      ex_rd = 5'd5;
      set_in(1'b1, 32'h00128313, 64'h114);
      flush = 1'b1;
      #1;
      checks++; if (b32.in_ready !== 1'b0) $display("FAIL fl_ready got %0b exp 0", b32.in_ready); else passed++;
      step();
      flush = 1'b0;
      ex_mem_read = 1'b0;
      set_in(1'b0, 32'h0, 64'h0);
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL fl_valid got %0b exp 0", b32.out_valid); else passed++;
      checks++; if (stall32 !== 32'd2) $display("FAIL fl_stall got %0d exp 2", stall32); else passed++;
   endtask

   task automatic test_formats();
      issue(32'h0020A423, 64'h120);
      checks++; if ({b32.out_ctrl.mem_write, b32.out_ctrl.xfer_size} !== {1'b1, 4'd4}) $display("FAIL sw_ctrl got %h exp 14", {b32.out_ctrl.mem_write, b32.out_ctrl.xfer_size}); else passed++;
      checks++; if (b32.out_imm !== 32'd8) $display("FAIL sw_imm got %h exp 8", b32.out_imm); else passed++;
      checks++; if ({b32.out_rd, b32.out_rs2} !== {5'd0, 5'd2}) $display("FAIL sw_regs got %h exp %h", {b32.out_rd, b32.out_rs2}, {5'd0, 5'd2}); else passed++;
      issue(32'hFE20EEE3, 64'h124);
      checks++; if (b32.out_ctrl.branch_type !== BR_LTU) $display("FAIL bltu_type got %0d exp 5", b32.out_ctrl.branch_type); else passed++;
      checks++; if (b32.out_ctrl.is_unsigned !== 1'b1) $display("FAIL bltu_uns got %0b exp 1", b32.out_ctrl.is_unsigned); else passed++;
      checks++; if (b32.out_imm !== 32'hFFFFFFFC) $display("FAIL bltu_imm got %h exp fffffffc", b32.out_imm); else passed++;
      issue(32'h123453B7, 64'h128);
      checks++; if (b32.out_imm !== 32'h12345000) $display("FAIL lui_imm got %h exp 12345000", b32.out_imm); else passed++;
      checks++; if ({b32.out_rs1, b32.out_rd} !== {5'd0, 5'd7}) $display("FAIL lui_regs got %h exp %h", {b32.out_rs1, b32.out_rd}, {5'd0, 5'd7}); else passed++;
      checks++; if (b32.out_ctrl.alu_op !== ALU_PASSB) $display("FAIL lui_aluop got %0d exp 5", b32.out_ctrl.alu_op); else passed++;
      issue(32'h40315093, 64'h12C);
      checks++; if ({b32.out_ctrl.shift, b32.out_ctrl.shift_type} !== {1'b1, SH_SRA}) $display("FAIL srai_ctrl got %h exp 6", {b32.out_ctrl.shift, b32.out_ctrl.shift_type}); else passed++;
      checks++; if (b32.out_imm !== 32'd3) $display("FAIL srai_imm got %h exp 3", b32.out_imm); else passed++;
      issue(32'h02009093, 64'h130);
      checks++; if (b32.out_ctrl !== ill) $display("FAIL slli32_ill got %h exp %h", b32.out_ctrl, ill); else passed++;
      checks++; if (b64.out_imm !== 64'd32) $display("FAIL slli64_imm got %h exp 20", b64.out_imm); else passed++;
      checks++; if (b64.out_ctrl.illegal !== 1'b0) $display("FAIL slli64_legal got %0b exp 0", b64.out_ctrl.illegal); else passed++;
      issue(32'h00000001, 64'h134);
      checks++; if (b32.out_ctrl !== ill) $display("FAIL rvc_ill32 got %h exp %h", b32.out_ctrl, ill); else passed++;
      checks++; if (b64.out_ctrl !== ill) $display("FAIL rvc_ill64 got %h exp %h", b64.out_ctrl, ill); else passed++;
      issue(32'h0000B083, 64'h138);
      checks++; if ({b64.out_ctrl.mem_read, b64.out_ctrl.xfer_size} !== {1'b1, 4'd8}) $display("FAIL ld64_ctrl got %h exp 18", {b64.out_ctrl.mem_read, b64.out_ctrl.xfer_size}); else passed++;
      checks++; if (b64.out_rd !== 5'd1) $display("FAIL ld64_rd got %0d exp 1", b64.out_rd); else passed++;
      checks++; if (b32.out_ctrl !== ill) $display("FAIL ld32_ill got %h exp %h", b32.out_ctrl, ill); else passed++;
      step();
   endtask

   task automatic test_reset_mid();
      issue(32'h123453B7, 64'h200);
      set_ready(1'b0);
      ex_mem_read = 1'b1;
      ex_rd = 5'd1;
      set_in(1'b1, 32'h00108133, 64'h204);
      repeat (5) step();
      checks++; if (stall32 !== 32'd7) $display("FAIL mid_stall got %0d exp 7", stall32); else passed++;
      checks++; if (b32.out_valid !== 1'b1) $display("FAIL mid_valid got %0b exp 1", b32.out_valid); else passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      ex_mem_read = 1'b0;
      set_in(1'b0, 32'h0, 64'h0);
      set_ready(1'b1);
      checks++; if (b32.out_valid !== 1'b0) $display("FAIL mrst_valid got %0b exp 0", b32.out_valid); else passed++;
      checks++; if (b32.out_ctrl !== ctrl_t'('0)) $display("FAIL mrst_ctrl got %h exp 0", b32.out_ctrl); else passed++;
      checks++; if (stall32 !== 32'd0) $display("FAIL mrst_stall32 got %0d exp 0", stall32); else passed++;
      checks++; if (stall64 !== 32'd0) $display("FAIL mrst_stall64 got %0d exp 0", stall64); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      ill = '0;
      ill.illegal = 1'b1;
      test_reset();
      test_addi();
      test_load_use();
      test_mul();
      test_back_pressure();
      test_flush();
      test_formats();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
